per2axi_res_arbiter: RTL and testbench
======================================

# per2axi_res_arbiter

Response-side scheduler for the per2axi bridge. It tracks outstanding transactions per AXI ID and backpressures new requests when an ID is saturated or has an atomic in flight. When the AXI R and B channels are valid in the same cycle, it arbitrates between them round-robin onto the single peripheral response port. It tells the response datapath which channel to forward and when to capture atomic read data.

## Interface
- PER_ID_WIDTH, 5, number of usable IDs; the peripheral response ID is one-hot of this width.
- AXI_ID_WIDTH, 3, AXI ID width; IDs >= PER_ID_WIDTH are illegal.
- MAX_OUTST, 2, maximum outstanding non-atomic transactions per ID (>=1).
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request-channel issue attempt (AR/AW accepted by datapath this cycle if ready).
- req_id_i  in  AXI_ID_WIDTH  ID of issuing request.
- req_atop_i  in  1  request is an atomic (expects both R and B).
- req_ready_o  out  1  issue permitted.
- r_valid_i  in  1  AXI R valid.
- r_id_i  in  AXI_ID_WIDTH  AXI R ID.
- r_last_i  in  1  AXI R last.
- r_ready_o  out  1  AXI R ready.
- b_valid_i  in  1  AXI B valid.
- b_id_i  in  AXI_ID_WIDTH  AXI B ID.
- b_ready_o  out  1  AXI B ready.
- res_valid_o  out  1  peripheral response valid this cycle.
- res_sel_b_o  out  1  response source: 0=R, 1=B.
- res_id_o  out  PER_ID_WIDTH  one-hot ID of response.
- atop_capture_o  out  1  pulse: R beat of an atomic; datapath latches read data, no peripheral response.
- spurious_o  out  1  pulse: response accepted for an ID with nothing outstanding.

## Operation
- Per-ID state: cnt[i] (clog2(MAX_OUTST+1) bits), atop[i], got_r[i], got_b[i]. Priority bit prio (0=R preferred).
- Issue: req_ready_o = (req_id_i < PER_ID_WIDTH) and not atop[id] and (req_atop_i ? cnt[id]==0 : cnt[id] < MAX_OUTST). Accept = req_valid_i and req_ready_o: cnt[id]++; if atomic, set atop[id] and clear got_r/got_b.
- Arbitration (combinational): if only one channel is valid, grant it. If both are valid, grant per prio, then toggle prio. prio toggles only on a contested grant. Granted channel ready=1, loser ready=0. With no valid, both readies=1.
- Non-atomic R handshake: res_valid_o=1, sel=0. Decrement cnt only when r_last_i=1.
- Non-atomic B handshake: res_valid_o=1, sel=1, cnt--.
- Atomic ID (atop[id]=1):
  - R handshake: atop_capture_o=1, res_valid_o=0, set got_r.
  - B handshake: set got_b; res_valid_o=0 unless got_r is already set.
  - When both got_r and got_b are set, exactly one response is issued: sel=1, and the datapath returns the captured data. This happens on the handshake that completes the pair; if that is an R beat, sel=1 and atop_capture_o=1 in the same cycle.
  - On completion: cnt=0 and atop cleared.
- Spurious response (cnt[id]==0 or id illegal): handshake with res_valid_o=0 and spurious_o=1; no state change.
- Same-cycle accept and completion on the same ID: the net cnt change is applied (+1-1=0). An atomic accept cannot coincide with a completion on the same ID because it requires cnt==0.

## Timing
- Grant, readies, res_* and pulses are combinational from inputs and current state. cnt, atop, got_* and prio update on the next rising clk_i.
- Response latency: 0 cycles from the AXI handshake to res_valid_o.
- Issue blocking takes effect in the cycle after the accept that saturates an ID.
- Reset state: all cnt=0, atop=got_r=got_b=0, prio=0.
- Output values in reset with inputs idle: req_ready_o=1 for legal IDs, r_ready_o=b_ready_o=1, res_valid_o=0, res_sel_b_o=0, res_id_o=0, atop_capture_o=0, spurious_o=0.
- Reset asserted mid-transaction discards all tracking. Post-reset responses for the old transactions are flagged spurious.
- A loser channel stalls for at most one cycle per contested pair (fairness bound).

## Test plan
- Single read, ID 2: accept; 1-beat R with last → res_valid_o=1, sel=0, res_id_o=5'b00100; cnt[2] returns to 0.
- Saturation, MAX_OUTST=2, ID 1: accept two writes → req_ready_o=0 for ID 1 and 1 for ID 0. One B → req_ready_o=1 next cycle.
- Contention: R on ID 0 and B on ID 3, both valid for 3 cycles → grants R, B, R; prio=1 after the sequence. Each loser's ready=0 in its stalled cycle.
- Atomic ID 4:
  - R first: atop_capture_o=1, res_valid_o=0.
  - B later: single response with sel=1, res_id_o=5'b10000.
  - Repeat with B first, then R: single response on the R handshake with sel=1 and capture=1.
  - While atop[4]=1, req_ready_o=0 for ID 4.
- Spurious: B on ID 6 (illegal) and R on idle ID 0 → spurious_o=1, res_valid_o=0, counters unchanged.
- Reset with cnt[1]=2: assert rst_ni=0 → req_ready_o=1 for all IDs, prio=0; a subsequent B on ID 1 → spurious_o=1.

Source files
------------

// File: rtl/per2axi_res_arbiter_if.sv
// Bundle of the per2axi response-arbiter signals: request issue, AXI R/B, peripheral response.
// The slave modport is the arbiter; the master modport is the surrounding datapath.
interface per2axi_res_arbiter_if #(
   parameter int unsigned PER_ID_WIDTH = 5,
   parameter int unsigned AXI_ID_WIDTH = 3
);
   logic                    req_valid_i;
   logic [AXI_ID_WIDTH-1:0] req_id_i;
   logic                    req_atop_i;
   logic                    req_ready_o;

   logic                    r_valid_i;
   logic [AXI_ID_WIDTH-1:0] r_id_i;
   logic                    r_last_i;
   logic                    r_ready_o;

   logic                    b_valid_i;
   logic [AXI_ID_WIDTH-1:0] b_id_i;
   logic                    b_ready_o;

   logic                    res_valid_o;
   logic                    res_sel_b_o;
   logic [PER_ID_WIDTH-1:0] res_id_o;
   logic                    atop_capture_o;
   logic                    spurious_o;

   modport slave (
      input  req_valid_i, req_id_i, req_atop_i,
      output req_ready_o,
      input  r_valid_i, r_id_i, r_last_i,
      output r_ready_o,
      input  b_valid_i, b_id_i,
      output b_ready_o,
      output res_valid_o, res_sel_b_o, res_id_o, atop_capture_o, spurious_o
   );

   modport master (
      output req_valid_i, req_id_i, req_atop_i,
      input  req_ready_o,
      output r_valid_i, r_id_i, r_last_i,
      input  r_ready_o,
      output b_valid_i, b_id_i,
      input  b_ready_o,
      input  res_valid_o, res_sel_b_o, res_id_o, atop_capture_o, spurious_o
   );
endinterface

// File: rtl/per2axi_res_arbiter.sv
// Response-side scheduler for per2axi: per-ID outstanding tracking, issue backpressure,
// round-robin R/B arbitration onto one peripheral response port, atomic R+B pairing.
module per2axi_res_arbiter #(
   parameter int unsigned PER_ID_WIDTH = 5,
   parameter int unsigned AXI_ID_WIDTH = 3,
   parameter int unsigned MAX_OUTST    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   per2axi_res_arbiter_if.slave  bus
);
   localparam int unsigned CW = $clog2(MAX_OUTST + 1);
   typedef logic [CW-1:0] cnt_t;
   typedef enum logic {PRIO_R = 1'b0, PRIO_B = 1'b1} prio_e;

   cnt_t                    cnt_q [PER_ID_WIDTH];
   cnt_t                    cnt_d [PER_ID_WIDTH];
   logic [PER_ID_WIDTH-1:0] atop_q, atop_d;
   logic [PER_ID_WIDTH-1:0] got_r_q, got_r_d;
   logic [PER_ID_WIDTH-1:0] got_b_q, got_b_d;
   prio_e                   prio_q, prio_d;

   logic                    req_legal, req_busy, req_ready, accept;
   cnt_t                    req_cnt;
   logic [PER_ID_WIDTH-1:0] req_onehot;

   logic                    contested, r_ready, b_ready, r_hs, b_hs, hs;
   logic [AXI_ID_WIDTH-1:0] rsp_id;
   logic                    rsp_legal, rsp_atop, rsp_got_r, rsp_got_b;
   cnt_t                    rsp_cnt;
   logic [PER_ID_WIDTH-1:0] rsp_onehot;

   // Per-ID lookups are decoded by comparison so that illegal IDs never index the arrays.
   always_comb begin
      req_legal  = 1'b0;
      req_busy   = 1'b0;
      req_cnt    = '0;
      req_onehot = '0;
      rsp_legal  = 1'b0;
      rsp_atop   = 1'b0;
      rsp_got_r  = 1'b0;
      rsp_got_b  = 1'b0;
      rsp_cnt    = '0;
      rsp_onehot = '0;
      for (int unsigned i = 0; i < PER_ID_WIDTH; i++) begin
         if (32'(bus.req_id_i) == i) begin
            req_legal     = 1'b1;
            req_busy      = atop_q[i];
            req_cnt       = cnt_q[i];
            req_onehot[i] = 1'b1;
         end
         if (32'(rsp_id) == i) begin
            rsp_legal     = 1'b1;
            rsp_atop      = atop_q[i];
            rsp_got_r     = got_r_q[i];
            rsp_got_b     = got_b_q[i];
            rsp_cnt       = cnt_q[i];
            rsp_onehot[i] = 1'b1;
         end
      end
   end

   assign req_ready = req_legal && !req_busy &&
                      (bus.req_atop_i ? (req_cnt == '0) : (req_cnt < cnt_t'(MAX_OUTST)));
   assign accept    = bus.req_valid_i && req_ready;

   assign contested = bus.r_valid_i && bus.b_valid_i;
   assign r_ready   = !contested || (prio_q == PRIO_R);
   assign b_ready   = !contested || (prio_q == PRIO_B);
   assign r_hs      = bus.r_valid_i && r_ready;
   assign b_hs      = bus.b_valid_i && b_ready;
   assign hs        = r_hs || b_hs;
   assign rsp_id    = b_hs ? bus.b_id_i : bus.r_id_i;

   assign bus.req_ready_o = req_ready;
   assign bus.r_ready_o   = r_ready;
   assign bus.b_ready_o   = b_ready;

   always_comb begin
      logic rsp_dec, rsp_done;
      bus.res_valid_o    = 1'b0;
      bus.res_sel_b_o    = 1'b0;
      bus.res_id_o       = '0;
      bus.atop_capture_o = 1'b0;
      bus.spurious_o     = 1'b0;
      rsp_dec            = 1'b0;
      rsp_done           = 1'b0;
      cnt_d              = cnt_q;
      atop_d             = atop_q;
      got_r_d            = got_r_q;
      got_b_d            = got_b_q;
      prio_d             = prio_q;

      if (contested) prio_d = (prio_q == PRIO_R) ? PRIO_B : PRIO_R;

      if (hs) begin
         if (!rsp_legal || rsp_cnt == '0) begin
            bus.spurious_o = 1'b1;
         end else if (rsp_atop) begin
            bus.atop_capture_o = r_hs;
            // The pair completes on whichever handshake arrives second; that one carries the response.
            if (r_hs ? rsp_got_b : rsp_got_r) begin
               bus.res_valid_o = 1'b1;
               bus.res_sel_b_o = 1'b1;
               rsp_done        = 1'b1;
            end else if (r_hs) begin
               got_r_d = got_r_q | rsp_onehot;
            end else begin
               got_b_d = got_b_q | rsp_onehot;
            end
         end else begin
            bus.res_valid_o = 1'b1;
            bus.res_sel_b_o = b_hs;
            rsp_dec         = b_hs || bus.r_last_i;
         end
         if (bus.res_valid_o) bus.res_id_o = rsp_onehot;
      end

      if (rsp_done) begin
         atop_d  = atop_q & ~rsp_onehot;
         got_r_d = got_r_q & ~rsp_onehot;
         got_b_d = got_b_q & ~rsp_onehot;
      end
      if (accept && bus.req_atop_i) begin
         atop_d  = atop_d | req_onehot;
         got_r_d = got_r_d & ~req_onehot;
         got_b_d = got_b_d & ~req_onehot;
      end

      for (int unsigned i = 0; i < PER_ID_WIDTH; i++) begin
         if (rsp_onehot[i] && rsp_dec)  cnt_d[i] = cnt_d[i] - cnt_t'(1);
         if (rsp_onehot[i] && rsp_done) cnt_d[i] = '0;
         if (req_onehot[i] && accept)   cnt_d[i] = cnt_d[i] + cnt_t'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '{default: '0};
         atop_q  <= '0;
         got_r_q <= '0;
         got_b_q <= '0;
         prio_q  <= PRIO_R;
      end else begin
         cnt_q   <= cnt_d;
         atop_q  <= atop_d;
         got_r_q <= got_r_d;
         got_b_q <= got_b_d;
         prio_q  <= prio_d;
      end
   end
endmodule

// File: tb/tb_per2axi_res_arbiter.sv
// Directed self-checking bench for per2axi_res_arbiter (PER_ID_WIDTH=5, AXI_ID_WIDTH=3, MAX_OUTST=2).
module tb_per2axi_res_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   per2axi_res_arbiter_if #(.PER_ID_WIDTH(5), .AXI_ID_WIDTH(3)) bus ();

   per2axi_res_arbiter #(
      .PER_ID_WIDTH(5),
      .AXI_ID_WIDTH(3),
      .MAX_OUTST   (2)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic v, input logic sel, input logic [4:0] id,
                          input logic cap, input logic spur);
      check({tag, ".res_valid"}, 32'(bus.res_valid_o), 32'(v));
      check({tag, ".res_sel_b"}, 32'(bus.res_sel_b_o), 32'(sel));
      check({tag, ".res_id"}, 32'(bus.res_id_o), 32'(id));
      check({tag, ".capture"}, 32'(bus.atop_capture_o), 32'(cap));
      check({tag, ".spurious"}, 32'(bus.spurious_o), 32'(spur));
   endtask

   task automatic req(input logic v, input logic [2:0] id, input logic atop);
      bus.req_valid_i = v; bus.req_id_i = id; bus.req_atop_i = atop;
   endtask

   task automatic rch(input logic v, input logic [2:0] id, input logic last);
      bus.r_valid_i = v; bus.r_id_i = id; bus.r_last_i = last;
   endtask

   task automatic bch(input logic v, input logic [2:0] id);
      bus.b_valid_i = v; bus.b_id_i = id;
   endtask

   task automatic idle();
      req(1'b0, 3'd0, 1'b0); rch(1'b0, 3'd0, 1'b0); bch(1'b0, 3'd0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      settle();
      // reset state with idle inputs
      check("rst.req_ready_id0", 32'(bus.req_ready_o), 32'd1);
      check("rst.r_ready", 32'(bus.r_ready_o), 32'd1);
      check("rst.b_ready", 32'(bus.b_ready_o), 32'd1);
      chk_res("rst", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
      req(1'b0, 3'd4, 1'b0); #1;
      check("rst.req_ready_id4", 32'(bus.req_ready_o), 32'd1);
      req(1'b0, 3'd5, 1'b0); #1;
      check("rst.req_ready_id5_illegal", 32'(bus.req_ready_o), 32'd0);
      req(1'b0, 3'd0, 1'b0);
      tick();
      rst_n = 1'b1;

      // single read on ID 2
      req(1'b1, 3'd2, 1'b0); settle();
      check("rd2.req_ready", 32'(bus.req_ready_o), 32'd1);
      tick(); req(1'b0, 3'd0, 1'b0);
      rch(1'b1, 3'd2, 1'b1); settle();
      check("rd2.r_ready", 32'(bus.r_ready_o), 32'd1);
      chk_res("rd2.resp", 1'b1, 1'b0, 5'b00100, 1'b0, 1'b0);
      tick(); settle();
      chk_res("rd2.again_spurious", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);
      tick(); idle();

      // saturation on ID 1
      req(1'b1, 3'd1, 1'b0); settle();
      check("sat.acc1_ready", 32'(bus.req_ready_o), 32'd1);
      tick(); settle();
      check("sat.acc2_ready", 32'(bus.req_ready_o), 32'd1);
      tick(); req(1'b0, 3'd1, 1'b0); settle();
      check("sat.id1_blocked", 32'(bus.req_ready_o), 32'd0);
      req(1'b0, 3'd0, 1'b0); #1;
      check("sat.id0_free", 32'(bus.req_ready_o), 32'd1);
      req(1'b0, 3'd1, 1'b0);
      bch(1'b1, 3'd1); #1;
      chk_res("sat.b1", 1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);
      check("sat.still_blocked_same_cycle", 32'(bus.req_ready_o), 32'd0);
      tick(); bch(1'b0, 3'd0); settle();
      check("sat.id1_unblocked", 32'(bus.req_ready_o), 32'd1);
      bch(1'b1, 3'd1); settle();
      chk_res("sat.b2", 1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);
      tick(); idle();

      // contention: read on ID 0, two writes on ID 3
      req(1'b1, 3'd0, 1'b0); tick();
      req(1'b1, 3'd3, 1'b0); tick(); tick();
      req(1'b0, 3'd0, 1'b0);
      rch(1'b1, 3'd0, 1'b0); bch(1'b1, 3'd3); settle();
      check("con1.r_ready", 32'(bus.r_ready_o), 32'd1);
      check("con1.b_ready", 32'(bus.b_ready_o), 32'd0);
      chk_res("con1", 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0);
      tick(); settle();
      check("con2.r_ready", 32'(bus.r_ready_o), 32'd0);
      check("con2.b_ready", 32'(bus.b_ready_o), 32'd1);
      chk_res("con2", 1'b1, 1'b1, 5'b01000, 1'b0, 1'b0);
      tick(); rch(1'b1, 3'd0, 1'b1); settle();
      check("con3.r_ready", 32'(bus.r_ready_o), 32'd1);
      check("con3.b_ready", 32'(bus.b_ready_o), 32'd0);
      chk_res("con3", 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0);
      tick(); rch(1'b1, 3'd0, 1'b0); settle();
      // prio is now B: B wins the next contested cycle
      check("con4.r_ready", 32'(bus.r_ready_o), 32'd0);
      check("con4.b_ready", 32'(bus.b_ready_o), 32'd1);
      chk_res("con4", 1'b1, 1'b1, 5'b01000, 1'b0, 1'b0);
      tick(); idle();

      // atomic on ID 4, R then B
      req(1'b1, 3'd4, 1'b1); settle();
      check("at1.req_ready", 32'(bus.req_ready_o), 32'd1);
      tick(); req(1'b0, 3'd4, 1'b0); settle();
      check("at1.blocked_plain", 32'(bus.req_ready_o), 32'd0);
      req(1'b0, 3'd4, 1'b1); #1;
      check("at1.blocked_atop", 32'(bus.req_ready_o), 32'd0);
      req(1'b0, 3'd3, 1'b0); #1;
      check("at1.id3_free", 32'(bus.req_ready_o), 32'd1);
      req(1'b0, 3'd0, 1'b0);
      rch(1'b1, 3'd4, 1'b1); #1;
      chk_res("at1.r", 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0);
      tick(); rch(1'b0, 3'd0, 1'b0); bch(1'b1, 3'd4); settle();
      chk_res("at1.b", 1'b1, 1'b1, 5'b10000, 1'b0, 1'b0);
      tick(); bch(1'b0, 3'd0); req(1'b0, 3'd4, 1'b1); settle();
      check("at1.released", 32'(bus.req_ready_o), 32'd1);

      // atomic on ID 4, B then R
      req(1'b1, 3'd4, 1'b1); tick(); req(1'b0, 3'd0, 1'b0);
      bch(1'b1, 3'd4); settle();
      chk_res("at2.b", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
      tick(); bch(1'b0, 3'd0); rch(1'b1, 3'd4, 1'b1); settle();
      chk_res("at2.r", 1'b1, 1'b1, 5'b10000, 1'b1, 1'b0);
      tick(); idle(); req(1'b0, 3'd4, 1'b0); settle();
      check("at2.released", 32'(bus.req_ready_o), 32'd1);
      req(1'b0, 3'd0, 1'b0);

      // spurious: illegal ID and idle ID
      bch(1'b1, 3'd6); settle();
      check("spu.b_ready", 32'(bus.b_ready_o), 32'd1);
      chk_res("spu.b6", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);
      tick(); bch(1'b0, 3'd0); rch(1'b1, 3'd0, 1'b1); settle();
      chk_res("spu.r0", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);
      tick(); idle(); req(1'b0, 3'd0, 1'b1); settle();
      check("spu.id0_unchanged", 32'(bus.req_ready_o), 32'd1);

      // reset mid-transaction
      req(1'b1, 3'd1, 1'b0); tick(); tick();
      req(1'b0, 3'd1, 1'b0); settle();
      check("rst2.id1_blocked", 32'(bus.req_ready_o), 32'd0);
      rch(1'b1, 3'd0, 1'b1); bch(1'b1, 3'd6); #1;
      check("rst2.con_r_ready", 32'(bus.r_ready_o), 32'd1);
      check("rst2.con_b_ready", 32'(bus.b_ready_o), 32'd0);
      check("rst2.con_spurious", 32'(bus.spurious_o), 32'd1);
      tick(); settle();
      check("rst2.prio_b_r_ready", 32'(bus.r_ready_o), 32'd0);
      rst_n = 1'b0; #1;
      check("rst2.id1_free", 32'(bus.req_ready_o), 32'd1);
      check("rst2.prio_r_r_ready", 32'(bus.r_ready_o), 32'd1);
      check("rst2.prio_r_b_ready", 32'(bus.b_ready_o), 32'd0);
      idle(); tick(); rst_n = 1'b1;
      bch(1'b1, 3'd1); settle();
      chk_res("rst2.old_b1", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);
      tick(); idle(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
